// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store with IDLE/WAIT/RESP handshake.
// Optional build macro DMEM_MISALIGN_TRAP_EN: misaligned halfword/word accesses
// return resp_err instead of being silently aligned down.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] CNT_LOAD = (LATENCY > 0) ? CW'(LATENCY - 1) : '0;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            lat_we_q;
    logic [2:0]      lat_funct3_q;
    logic [31:0]     lat_addr_q;
    logic [31:0]     lat_wdata_q;

    logic [31:0]     resp_rdata_q;
    logic            resp_err_q;

    logic [31:0]     mem_q [DEPTH_WORDS];

    logic            accept;
    logic            enter_resp;

    logic            op_we;
    logic [2:0]      op_funct3;
    logic [31:0]     op_addr;
    logic [31:0]     op_wdata;

    logic [1:0]      lane;
    logic [1:0]      eff_lane;
    logic [AW-1:0]   idx;
    logic            in_range;
    logic            fn_ok;
    logic            misalign;
    logic            err;
    logic            wr_en;
    logic [3:0]      be;
    logic [31:0]     wword;
    logic [31:0]     rword;
    logic [31:0]     shifted;
    logic [31:0]     load_data;
    logic [31:0]     rdata_d;

    assign accept = req_valid && req_ready;

    // State and wait counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (LATENCY == 0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Handshake outputs decoded from the registered state
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        unique case (state_q)
            ST_IDLE: req_ready  = 1'b1;
            ST_RESP: resp_valid = 1'b1;
            default: ;
        endcase
    end

    assign enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);

    // Capture the request fields on the accept edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_we_q     <= 1'b0;
            lat_funct3_q <= '0;
            lat_addr_q   <= '0;
            lat_wdata_q  <= '0;
        end else if (accept) begin
            lat_we_q     <= req_we;
            lat_funct3_q <= req_funct3;
            lat_addr_q   <= req_addr;
            lat_wdata_q  <= req_wdata;
        end
    end

    // Operand source: live inputs when a zero-latency accept goes straight to RESP
    always_comb begin
        if (state_q == ST_IDLE) begin
            op_we     = req_we;
            op_funct3 = req_funct3;
            op_addr   = req_addr;
            op_wdata  = req_wdata;
        end else begin
            op_we     = lat_we_q;
            op_funct3 = lat_funct3_q;
            op_addr   = lat_addr_q;
            op_wdata  = lat_wdata_q;
        end
    end

    assign lane     = op_addr[1:0];
    assign idx      = op_addr[AW+1:2];
    assign in_range = (op_addr[31:2] < 30'(DEPTH_WORDS));

`ifdef DMEM_MISALIGN_TRAP_EN
    // Halfword needs addr[0]=0, word needs addr[1:0]=0
    always_comb begin
        misalign = 1'b0;
        case (op_funct3)
            F3_H, F3_HU: misalign = lane[0];
            F3_W:        misalign = |lane;
            default:     misalign = 1'b0;
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    // Width legality and size-aligned byte lane
    always_comb begin
        eff_lane = lane;
        fn_ok    = 1'b0;
        case (op_funct3)
            F3_B:        fn_ok = 1'b1;
            F3_H:        begin fn_ok = 1'b1;    eff_lane = {lane[1], 1'b0}; end
            F3_W:        begin fn_ok = 1'b1;    eff_lane = 2'b00;           end
            F3_BU:       fn_ok = !op_we;
            F3_HU:       begin fn_ok = !op_we;  eff_lane = {lane[1], 1'b0}; end
            default:     fn_ok = 1'b0;
        endcase
    end

    assign err   = !in_range || !fn_ok || misalign;
    assign wr_en = enter_resp && op_we && !err && !reset;

    // Store byte enables and lane-replicated write data
    always_comb begin
        be    = 4'b0000;
        wword = op_wdata;
        case (op_funct3)
            F3_B: begin
                be    = 4'b0001 << eff_lane;
                wword = {4{op_wdata[7:0]}};
            end
            F3_H: begin
                be    = 4'b0011 << eff_lane;
                wword = {2{op_wdata[15:0]}};
            end
            F3_W: begin
                be    = 4'b1111;
                wword = op_wdata;
            end
            default: ;
        endcase
    end

    // Storage array; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[idx][8*b +: 8] <= wword[8*b +: 8];
                end
            end
        end
    end

    assign rword   = mem_q[idx];
    assign shifted = rword >> {eff_lane, 3'b000};

    // Load extraction and extension
    always_comb begin
        load_data = '0;
        case (op_funct3)
            F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    load_data = rword;
            F3_BU:   load_data = {24'd0, shifted[7:0]};
            F3_HU:   load_data = {16'd0, shifted[15:0]};
            default: load_data = '0;
        endcase
    end

    assign rdata_d = (err || op_we) ? 32'd0 : load_data;

    // Response payload registered on the edge that enters RESP
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else if (enter_resp) begin
            resp_rdata_q <= rdata_d;
            resp_err_q   <= err;
        end
    end

    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (DEPTH_WORDS=256, LATENCY=1).
module tb_dmem_responder;

    localparam int unsigned LAT = 1;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int passed = 0;
    int total  = 0;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One transaction starting at a negedge with the DUT idle; holds resp_ready low for 'hold' cycles
    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err, input int hold);
        int cycles;
        logic [31:0] first_rdata;
        chk({tag, ".ready"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        cycles = 0;
        while (cycles < 20) begin
            @(negedge clk);
            cycles++;
            if (resp_valid) break;
            // Junk on the request bus must be ignored while busy
            req_valid  = 1'b1;
            req_we     = 1'b1;
            req_funct3 = 3'd2;
            req_addr   = 32'h0000_0010;
            req_wdata  = 32'hBAD0_BAD0;
        end
        req_valid = 1'b0;
        chk({tag, ".lat"}, 32'(cycles), 32'(LAT + 1));
        chk({tag, ".rdata"}, resp_rdata, exp_rdata);
        chk({tag, ".err"}, 32'(resp_err), 32'(exp_err));
        first_rdata = resp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, ".hold_valid"}, 32'(resp_valid), 32'd1);
            chk({tag, ".hold_rdata"}, resp_rdata, first_rdata);
            chk({tag, ".hold_ready"}, 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        chk({tag, ".post_ready"}, 32'(req_ready), 32'd1);
        chk({tag, ".post_valid"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        resp_ready = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst.ready", 32'(req_ready), 32'd1);
        chk("rst.valid", 32'(resp_valid), 32'd0);
        chk("rst.rdata", resp_rdata, 32'd0);
        chk("rst.err",   32'(resp_err), 32'd0);
        reset = 1'b0;

        // Word store/load round trip
        do_req("sw10",  1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0);
        do_req("lw10",  1'b0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0);

        // Byte store into a zeroed word, sign/zero extension
        do_req("sw10z", 1'b1, 3'd2, 32'h10, 32'h0, 32'h0, 1'b0, 0);
        do_req("sb13",  1'b1, 3'd0, 32'h13, 32'h80, 32'h0, 1'b0, 0);
        do_req("lb13",  1'b0, 3'd0, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 0);
        do_req("lbu13", 1'b0, 3'd4, 32'h13, 32'h0, 32'h00000080, 1'b0, 0);
        do_req("lw10b", 1'b0, 3'd2, 32'h10, 32'h0, 32'h80000000, 1'b0, 0);

        // Halfword and partial byte writes leave other lanes intact
        do_req("sh12",  1'b1, 3'd1, 32'h12, 32'hAAAA1234, 32'h0, 1'b0, 0);
        do_req("lw10c", 1'b0, 3'd2, 32'h10, 32'h0, 32'h12340000, 1'b0, 0);
        do_req("lhu12", 1'b0, 3'd5, 32'h12, 32'h0, 32'h00001234, 1'b0, 0);
        do_req("sb11",  1'b1, 3'd0, 32'h11, 32'hAAAAAAF7, 32'h0, 1'b0, 0);
        do_req("lw10d", 1'b0, 3'd2, 32'h10, 32'h0, 32'h1234F700, 1'b0, 0);
        do_req("lh10",  1'b0, 3'd1, 32'h10, 32'h0, 32'hFFFFF700, 1'b0, 0);

        // Misaligned halfword load
`ifdef DMEM_MISALIGN_TRAP_EN
        do_req("lh11",  1'b0, 3'd1, 32'h11, 32'h0, 32'h0, 1'b1, 0);
`else
        do_req("lh11",  1'b0, 3'd1, 32'h11, 32'h0, 32'hFFFFF700, 1'b0, 0);
`endif

        // Address range boundary: last word valid, 0x400 out of range and aliasing word 0 untouched
        do_req("sw3fc", 1'b1, 3'd2, 32'h3FC, 32'h5A5A5A5A, 32'h0, 1'b0, 0);
        do_req("lw3fc", 1'b0, 3'd2, 32'h3FC, 32'h0, 32'h5A5A5A5A, 1'b0, 0);
        do_req("sw0",   1'b1, 3'd2, 32'h0, 32'h11111111, 32'h0, 1'b0, 0);
        do_req("sw400", 1'b1, 3'd2, 32'h400, 32'hFFFFFFFF, 32'h0, 1'b1, 0);
        do_req("lw0",   1'b0, 3'd2, 32'h0, 32'h0, 32'h11111111, 1'b0, 0);
        do_req("lw400", 1'b0, 3'd2, 32'h400, 32'h0, 32'h0, 1'b1, 0);

        // Illegal funct3 codes
        do_req("ld_f3", 1'b0, 3'd3, 32'h10, 32'h0, 32'h0, 1'b1, 0);
        do_req("ld_f6", 1'b0, 3'd6, 32'h10, 32'h0, 32'h0, 1'b1, 0);
        do_req("st_f3", 1'b1, 3'd3, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1, 0);
        do_req("st_f4", 1'b1, 3'd4, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1, 0);
        do_req("lw10e", 1'b0, 3'd2, 32'h10, 32'h0, 32'h1234F700, 1'b0, 0);

        // Back-pressure on the response
        do_req("hold",  1'b0, 3'd2, 32'h10, 32'h0, 32'h1234F700, 1'b0, 5);

        // Reset during WAIT drops the pending store
        do_req("sw20",  1'b1, 3'd2, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0, 0);
        chk("rw.ready", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'd2;
        req_addr   = 32'h20;
        req_wdata  = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rw.in_wait_ready", 32'(req_ready), 32'd0);
        reset = 1'b1;
        #1;
        chk("rw.rst_valid", 32'(resp_valid), 32'd0);
        chk("rw.rst_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("rw.rst_valid2", 32'(resp_valid), 32'd0);
        reset = 1'b0;
        do_req("lw20",  1'b0, 3'd2, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256: number of 32-bit storage words, power of two, 16..4096.
REQ-002 SHALL have parameter LATENCY, default 1: wait cycles between request accept and response, 0..15.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  the initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  the responder can accept a request.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_funct3  input  3  RISC-V load/store width code (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port resp_valid  output  1  a response is held.
REQ-012 SHALL have port resp_ready  input  1  the initiator accepts the response.
REQ-013 SHALL have port resp_rdata  output  32  load result, extended per funct3; 0 for stores and errors.
REQ-014 SHALL have port resp_err  output  1  the request failed; no memory side effect occurred.

Function
REQ-015 SHALL implement the states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 SHALL accept a request when req_valid and req_ready are both 1, and SHALL latch we, funct3, addr and wdata on that edge.
REQ-017 On accept, SHALL go to RESP when LATENCY=0, otherwise to WAIT with a down-counter loaded to LATENCY-1.
REQ-018 In WAIT, SHALL decrement the counter each cycle and go to RESP on the cycle after the counter reaches 0 (accept-to-resp_valid = LATENCY+1 cycles).
REQ-019 SHALL perform the memory read and write, and register resp_rdata and resp_err, on the edge that enters RESP.
REQ-020 In RESP, SHALL hold resp_valid, resp_rdata and resp_err stable until resp_ready=1, then go to IDLE on that edge.
REQ-021 SHALL NOT accept a new request in the same cycle as the response handshake; the minimum request spacing is LATENCY+2 cycles.
REQ-022 SHALL decode word index = addr[31:2] and byte lane = addr[1:0].
REQ-023 Stores: SB SHALL write one byte at its lane; SH SHALL write bytes {lane+1, lane}; SW SHALL write all 4 bytes; other bytes SHALL be unchanged.
REQ-024 Loads: LB/LH SHALL sign-extend, LBU/LHU SHALL zero-extend, and LW SHALL return the full word.
REQ-025 resp_err SHALL be 1 when the word index is >= DEPTH_WORDS, for a load with funct3 in {3,6,7}, or for a store with funct3 > 2.
REQ-026 A request with resp_err=1 SHALL NOT modify memory and SHALL return resp_rdata=0.
REQ-027 Inputs SHALL be ignored outside the accept cycle; changes to req_* during WAIT or RESP SHALL have no effect.

Reset
REQ-028 reset=1 SHALL force IDLE immediately: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, counter=0.
REQ-029 Reset during WAIT SHALL drop the pending request, including any pending store; memory contents SHALL NOT be cleared by reset.
REQ-030 The first request SHALL be accepted on the first rising edge after reset deasserts with req_valid=1.

Configuration
REQ-031 Macro DMEM_MISALIGN_TRAP_EN defined: a misaligned access (LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0) SHALL give resp_err=1 with no write.
REQ-032 Macro DMEM_MISALIGN_TRAP_EN undefined: the low address bits SHALL be masked to the access size (halfword: addr[0]=0; word: addr[1:0]=0) and the access SHALL complete with no error.

Verification
REQ-033 LATENCY=1: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rdata=0xDEADBEEF, err=0, resp_valid 2 cycles after each accept.
REQ-034 SB 0x13 data 0x80 onto word 0x00000000, then LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LW 0x10 -> 0x80000000.
REQ-035 LW addr 0x400 with DEPTH_WORDS=256 -> err=1, rdata=0; SW 0x400 leaves all memory unchanged.
REQ-036 Hold resp_ready=0 for 5 cycles -> resp_valid and resp_rdata stay stable and req_ready=0; after the handshake, req_ready=1 on the next cycle.
REQ-037 Assert reset during WAIT of SW 0x20 data 0x12345678 -> after reset, LW 0x20 returns the old value and resp_valid=0 during reset.
REQ-038 LH addr 0x11: with DMEM_MISALIGN_TRAP_EN -> err=1; without it -> data from halfword 0x10, err=0.
